// File: rtl/frame_writer.sv
// frame_writer
//   Terminal output stage of the pixel pipeline. Incoming RGB pixels are
//   queued in a first-word-fall-through FIFO, packed as {8'h00, R, G, B},
//   and written to memory as address-incrementing bursts over a req/ack
//   handshake. After the last word of a frame, oDone pulses for one cycle
//   and the write address rewinds to baseAddr.
//
//   Optional feature macro: FRAME_WRITER_CHECKSUM_EN
//     defined   -> 32-bit running sum of transferred words, latched into
//                  oChecksum at the end of every frame
//     undefined -> oChecksum is constant zero
//
// Ports
//   clk        : clock, all logic on the rising edge
//   reset      : synchronous, active-high
//   iValid     : a pixel is presented this cycle
//   iR/iG/iB   : pixel components (8-bit unsigned)
//   oWrReq     : write request, held until acknowledged
//   iWrAck     : memory accepts; transfer when oWrReq && iWrAck
//   oWrAddress : byte address of the current word
//   oWrData    : current word (FIFO head), zero when the FIFO is empty
//   oLevel     : FIFO occupancy
//   oOverflow  : sticky, a pixel was dropped because the FIFO was full
//   oChecksum  : checksum of the last completed frame
//   oDone      : one-cycle pulse after the final word of a frame
module frame_writer #(
  parameter int unsigned width     = 1920,
  parameter int unsigned height    = 1080,
  parameter logic [31:0] baseAddr  = 32'h0,
  parameter int unsigned burstLen  = 8,
  parameter int unsigned fifoDepth = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         iValid,
  input  logic [7:0]                   iR,
  input  logic [7:0]                   iG,
  input  logic [7:0]                   iB,
  output logic                         oWrReq,
  input  logic                         iWrAck,
  output logic [31:0]                  oWrAddress,
  output logic [31:0]                  oWrData,
  output logic [$clog2(fifoDepth):0]   oLevel,
  output logic                         oOverflow,
  output logic [31:0]                  oChecksum,
  output logic                         oDone
);

  localparam int unsigned aw        = $clog2(fifoDepth);
  localparam int unsigned lw        = aw + 1;
  localparam logic [31:0] frameSize = 32'(width * height);
  localparam logic [31:0] burstLenW = 32'(burstLen);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } stateT;

  stateT          state;
  stateT          stateNext;
  logic [23:0]    mem [fifoDepth];
  logic [aw-1:0]  wrPtr;
  logic [aw-1:0]  rdPtr;
  logic [lw-1:0]  level;
  logic [lw-1:0]  burstCnt;
  logic [31:0]    wordsWritten;
  logic [31:0]    wrAddr;
  logic [31:0]    remaining;
  logic [31:0]    burstWords;
  logic           full;
  logic           push;
  logic           pop;
  logic           loadBurst;
  logic           lastOfBurst;
  logic           lastOfFrame;
  logic           overflow;

  // Datapath decode: FIFO handshakes and burst sizing.
  always_comb begin
    full        = (level == lw'(fifoDepth));
    push        = iValid && !full;
    pop         = (state == BURST) && iWrAck;
    remaining   = frameSize - wordsWritten;
    // The last burst of a frame is shortened to whatever is left.
    burstWords  = (remaining < burstLenW) ? remaining : burstLenW;
    lastOfBurst = (burstCnt == lw'(1));
    lastOfFrame = (wordsWritten == (frameSize - 32'd1));
  end

  // Next-state logic of the burst controller.
  always_comb begin
    stateNext = state;
    loadBurst = 1'b0;
    case (state)
      IDLE: begin
        // A burst starts only once all of its words are already queued,
        // so a burst never stalls waiting for input.
        if (32'(level) >= burstWords) begin
          stateNext = BURST;
          loadBurst = 1'b1;
        end else begin
          stateNext = IDLE;
        end
      end
      BURST: begin
        if (pop && lastOfBurst) begin
          if (lastOfFrame) begin
            stateNext = DONE;
          end else begin
            stateNext = IDLE;
          end
        end else begin
          stateNext = BURST;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // FIFO storage; contents need no reset because the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= {iR, iG, iB};
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + aw'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + aw'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + lw'(1);
        2'b01:   level <= level - lw'(1);
        default: level <= level;
      endcase
      // Drop is judged on the registered level, even if a pop happens now.
      if (iValid && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Frame word counter, write address and burst word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wordsWritten <= 32'd0;
      wrAddr       <= baseAddr;
      burstCnt     <= '0;
    end else if (state == DONE) begin
      wordsWritten <= 32'd0;
      wrAddr       <= baseAddr;
    end else begin
      if (loadBurst) begin
        burstCnt <= burstWords[lw-1:0];
      end
      if (pop) begin
        wordsWritten <= wordsWritten + 32'd1;
        wrAddr       <= wrAddr + 32'd4;
        burstCnt     <= burstCnt - lw'(1);
      end
    end
  end

`ifdef FRAME_WRITER_CHECKSUM_EN
  logic [31:0] checksumAcc;
  logic [31:0] checksumOut;

  // Frame checksum: sum of transferred words, published at end of frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksumAcc <= 32'd0;
      checksumOut <= 32'd0;
    end else if (state == DONE) begin
      checksumOut <= checksumAcc;
      checksumAcc <= 32'd0;
    end else if (pop) begin
      checksumAcc <= checksumAcc + oWrData;
    end
  end

  assign oChecksum = checksumOut;
`else
  assign oChecksum = 32'h0;
`endif

  assign oWrReq     = (state == BURST);
  assign oDone      = (state == DONE);
  assign oWrAddress = wrAddr;
  assign oLevel     = level;
  assign oOverflow  = overflow;
  // Fall-through head of the FIFO; forced to zero when nothing is queued.
  assign oWrData    = (level != '0) ? {8'h00, mem[rdPtr]} : 32'h0;

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer (4x2 frame, bursts of 4, FIFO of 8,
// base 0x100) plus a second 3x1 instance for the short final burst.
// A queue-based reference model tracks queued pixels, the word index in the
// frame, sticky overflow, end-of-frame pulse and frame checksum.
module tb_frame_writer;

  localparam logic [31:0] BASE    = 32'h100;
  localparam int          DEPTH   = 8;
  localparam int          FRAMESZ = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        iValid, iWrAck;
  logic [7:0]  iR, iG, iB;
  logic        oWrReq, oOverflow, oDone;
  logic [31:0] oWrAddress, oWrData, oChecksum;
  logic [3:0]  oLevel;

  logic        iValid2, iWrAck2;
  logic [7:0]  iR2, iG2, iB2;
  logic        oWrReq2, oOverflow2, oDone2;
  logic [31:0] oWrAddress2, oWrData2, oChecksum2;
  logic [3:0]  oLevel2;

  always #5 clk = ~clk;

  frame_writer #(.width(4), .height(2), .baseAddr(32'h100), .burstLen(4), .fifoDepth(8)) dut (
    .clk(clk), .reset(reset), .iValid(iValid), .iR(iR), .iG(iG), .iB(iB),
    .oWrReq(oWrReq), .iWrAck(iWrAck), .oWrAddress(oWrAddress), .oWrData(oWrData),
    .oLevel(oLevel), .oOverflow(oOverflow), .oChecksum(oChecksum), .oDone(oDone));

  frame_writer #(.width(3), .height(1), .baseAddr(32'h100), .burstLen(4), .fifoDepth(8)) dut2 (
    .clk(clk), .reset(reset), .iValid(iValid2), .iR(iR2), .iG(iG2), .iB(iB2),
    .oWrReq(oWrReq2), .iWrAck(iWrAck2), .oWrAddress(oWrAddress2), .oWrData(oWrData2),
    .oLevel(oLevel2), .oOverflow(oOverflow2), .oChecksum(oChecksum2), .oDone(oDone2));

  int tests  = 0;
  int failed = 0;

  // reference model state
  logic [23:0] q[$];
  bit          mOvf;
  bit          mDone;
  int          mIdx;
  logic [31:0] mSum, mDoneSum, mChk;
  int          cyc, xfers, doneCnt;
  int          xferCyc[$];
  int          pushCyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample handshake before the edge, advance the model,
  // then compare every observable output just after the edge.
  task automatic cycle();
    bit          xfer, pushOk, drop, wasDone, rst;
    logic [23:0] px, head;
    int          c;
    rst     = (reset === 1'b1);
    xfer    = (oWrReq === 1'b1) && (iWrAck === 1'b1);
    pushOk  = (iValid === 1'b1) && (q.size() < DEPTH);
    drop    = (iValid === 1'b1) && (q.size() == DEPTH);
    px      = {iR, iG, iB};
    wasDone = mDone;
    c       = cyc;
    if (!rst && xfer) begin
      chk("xferAddr", oWrAddress, BASE + 32'(4 * mIdx));
      chk("xferData", oWrData, (q.size() > 0) ? {8'h00, q[0]} : 32'hDEAD_BEEF);
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      mOvf = 1'b0; mDone = 1'b0; mIdx = 0;
      mSum = 32'h0; mDoneSum = 32'h0; mChk = 32'h0;
    end else begin
      if (wasDone) begin
        mIdx = 0;
`ifdef FRAME_WRITER_CHECKSUM_EN
        mChk = mDoneSum;
`endif
      end
      mDone = 1'b0;
      if (xfer && q.size() > 0) begin
        head = q.pop_front();
        mSum = mSum + {8'h00, head};
        mIdx++;
        xfers++;
        xferCyc.push_back(c);
        if (mIdx == FRAMESZ) begin
          mDone    = 1'b1;
          mDoneSum = mSum;
          mSum     = 32'h0;
          doneCnt++;
        end
      end
      if (pushOk) begin
        q.push_back(px);
        pushCyc.push_back(c);
      end
      if (drop) mOvf = 1'b1;
    end
    #1;
    chk("level", 32'(oLevel), 32'(q.size()));
    chk("overflow", 32'(oOverflow), 32'(mOvf));
    chk("done", 32'(oDone), 32'(mDone));
    chk("address", oWrAddress, BASE + 32'(4 * mIdx));
    chk("headData", oWrData, (q.size() > 0) ? {8'h00, q[0]} : 32'h0);
    chk("checksum", oChecksum, mChk);
    if (rst) chk("rstWrReq", 32'(oWrReq), 32'h0);
  endtask

  task automatic clearLog();
    xfers = 0; doneCnt = 0;
    xferCyc.delete(); pushCyc.delete();
  endtask

  task automatic doReset(input int n);
    reset = 1'b1; iValid = 1'b0;
    repeat (n) cycle();
    reset = 1'b0;
    clearLog();
  endtask

  task automatic sendPixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    iValid = 1'b1; iR = r; iG = g; iB = b;
    cycle();
    iValid = 1'b0;
  endtask

  task automatic runUntilDone(input int budget);
    int start = doneCnt;
    int n = 0;
    while (doneCnt == start && n < budget) begin
      cycle();
      n++;
    end
    chk("doneWithinBudget", 32'(doneCnt - start), 32'd1);
  endtask

  initial begin
    int          p2Addr[$];
    logic [31:0] p2Data[$];
    int          p2Cyc[$];
    int          p2Done;
    reset = 1'b1; iValid = 1'b0; iWrAck = 1'b0; iR = 8'h0; iG = 8'h0; iB = 8'h0;
    iValid2 = 1'b0; iWrAck2 = 1'b0; iR2 = 8'h0; iG2 = 8'h0; iB2 = 8'h0;
    mOvf = 1'b0; mDone = 1'b0; mIdx = 0; mSum = 32'h0; mDoneSum = 32'h0; mChk = 32'h0;
    cyc = 0;
    clearLog();

    // reset values
    doReset(3);
    chk("rst.wrReq", 32'(oWrReq), 32'h0);
    chk("rst.addr", oWrAddress, 32'h100);
    chk("rst.level", 32'(oLevel), 32'h0);
    chk("rst.ovf", 32'(oOverflow), 32'h0);
    chk("rst.done", 32'(oDone), 32'h0);
    chk("rst.chk", oChecksum, 32'h0);
    chk("rst.data", oWrData, 32'h0);

    // full frame, back-to-back pixels, ack held high
    iWrAck = 1'b1;
    for (int i = 0; i < 8; i++) sendPixel(8'(i), 8'(i + 1), 8'(i + 2));
    runUntilDone(40);
    cycle();
    chk("frame.rewind", oWrAddress, 32'h100);
    chk("frame.xfers", 32'(xferCyc.size()), 32'd8);
    if (xferCyc.size() == 8 && pushCyc.size() == 8) begin
      chk("frame.latency", 32'(xferCyc[0] - pushCyc[3]), 32'd2);
      for (int k = 1; k < 8; k++)
        chk("frame.spacing", 32'(xferCyc[k] - xferCyc[k-1]), (k == 4) ? 32'd2 : 32'd1);
    end

    // overflow: memory stalled while 9 pixels arrive
    doReset(1);
    iWrAck = 1'b0;
    for (int i = 0; i < 9; i++) sendPixel(8'($urandom), 8'($urandom), 8'($urandom));
    chk("ovf.level", 32'(oLevel), 32'd8);
    chk("ovf.flag", 32'(oOverflow), 32'd1);
    repeat (3) cycle();
    chk("ovf.sticky", 32'(oOverflow), 32'd1);
    iWrAck = 1'b1;
    runUntilDone(40);
    chk("ovf.xfers", 32'(xfers), 32'd8);
    chk("ovf.stickyAfter", 32'(oOverflow), 32'd1);

    // checksum of eight 0x010101 words
    doReset(1);
    for (int i = 0; i < 8; i++) sendPixel(8'd1, 8'd1, 8'd1);
    runUntilDone(40);
    cycle();
`ifdef FRAME_WRITER_CHECKSUM_EN
    chk("checksum.value", oChecksum, 32'h0008_0808);
`else
    chk("checksum.value", oChecksum, 32'h0);
`endif

    // reset after the second transfer of the first burst
    doReset(1);
    for (int i = 0; i < 20 && xfers < 2; i++) begin
      iValid = 1'b1; iR = 8'($urandom); iG = 8'($urandom); iB = 8'($urandom);
      cycle();
    end
    chk("midRst.twoXfers", 32'(xfers), 32'd2);
    doReset(1);
    chk("midRst.level", 32'(oLevel), 32'd0);
    chk("midRst.wrReq", 32'(oWrReq), 32'd0);
    for (int i = 0; i < 8; i++) sendPixel(8'($urandom), 8'($urandom), 8'($urandom));
    runUntilDone(40);

    // randomized traffic with random back-pressure
    doReset(1);
    for (int i = 0; i < 400; i++) begin
      iValid = ($urandom_range(0, 99) < 60);
      iWrAck = ($urandom_range(0, 99) < 70);
      iR = 8'($urandom); iG = 8'($urandom); iB = 8'($urandom);
      cycle();
    end
    iValid = 1'b0; iWrAck = 1'b1;
    repeat (20) cycle();
    chk("random.framesDone", 32'(doneCnt >= 10), 32'd1);

    // short final burst on the 3x1 instance
    doReset(1);
    iWrAck = 1'b0;
    iWrAck2 = 1'b1;
    p2Done = -1;
    for (int i = 0; i < 30; i++) begin
      iValid2 = (i < 3);
      iR2 = 8'(8'h10 + i); iG2 = 8'(8'h20 + i); iB2 = 8'(8'h30 + i);
      if (oWrReq2 && iWrAck2) begin
        p2Addr.push_back(int'(oWrAddress2));
        p2Data.push_back(oWrData2);
        p2Cyc.push_back(cyc);
      end
      if (oDone2 && p2Done < 0) p2Done = cyc;
      cycle();
    end
    iValid2 = 1'b0;
    chk("partial.count", 32'(p2Addr.size()), 32'd3);
    if (p2Addr.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("partial.addr", 32'(p2Addr[k]), 32'h100 + 32'(4 * k));
        chk("partial.data", p2Data[k], {8'h00, 8'(8'h10 + k), 8'(8'h20 + k), 8'(8'h30 + k)});
      end
      chk("partial.contiguous", 32'(p2Cyc[2] - p2Cyc[0]), 32'd2);
      chk("partial.doneCycle", 32'(p2Done - p2Cyc[2]), 32'd1);
    end
    chk("partial.rewind", oWrAddress2, 32'h100);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
